one_hot_codec: RTL and testbench

- Parametrised, registered, bidirectional one-hot codec; the successor to the combinational 4-bit binary-to-one-hot encoder.
- Encode mode: binary -> one-hot. Decode mode: one-hot -> binary, with invalid-code detection.
- Sits between a producer and a consumer on valid/ready streams, with one registered output stage and full backpressure.

---
 rtl/one_hot_codec.sv | 99 +++++++++
 tb/tb_one_hot_codec.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/one_hot_codec.sv
// one_hot_codec: registered, bidirectional binary <-> one-hot codec on a
// valid/ready stream with a single output register and full backpressure.
//
// Build option: define ONE_HOT_ERR_CNT_EN to add a saturating 16-bit counter
// of accepted decode words that were not exactly one-hot (err_clr_i/err_cnt_o).
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   mode_i        0 = encode (bin_i -> oh_o), 1 = decode (oh_i -> bin_o)
//   in_valid_i    input word valid
//   in_ready_o    input can be accepted this cycle (combinational)
//   bin_i, oh_i   binary / one-hot input words
//   out_valid_o   output register holds a result
//   out_ready_i   consumer takes the result
//   oh_o, bin_o   encoded / decoded result (the unused one reads zero)
//   err_o         decode input was not exactly one-hot
//   mode_o        mode of the word held in the output register
//   err_clr_i     (option) synchronous counter clear, wins over increment
//   err_cnt_o     (option) saturating count of decode errors
module one_hot_codec #(
  parameter int unsigned BIN_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [BIN_W-1:0]        bin_i,
  input  logic [(2**BIN_W)-1:0]   oh_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [(2**BIN_W)-1:0]   oh_o,
  output logic [BIN_W-1:0]        bin_o,
  output logic                    err_o,
  output logic                    mode_o
`ifdef ONE_HOT_ERR_CNT_EN
  ,
  input  logic                    err_clr_i,
  output logic [15:0]             err_cnt_o
`endif
);

  localparam int unsigned OH_W = 2 ** BIN_W;

  logic             accept;
  logic [OH_W-1:0]  enc_oh;
  logic [BIN_W-1:0] dec_bin;
  logic             dec_err;

  // Output register is free when empty or being drained this cycle.
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  assign enc_oh = OH_W'(1) << bin_i;

  // Lowest set bit wins; scanning downward leaves the lowest index last.
  always_comb begin
    dec_bin = '0;
    for (int i = int'(OH_W) - 1; i >= 0; i--) begin
      if (oh_i[i]) dec_bin = BIN_W'(i);
    end
  end

  // Not one-hot: zero, or more than one bit set.
  assign dec_err = (oh_i == '0) || ((oh_i & (oh_i - OH_W'(1))) != '0);

  // Output stage: load on accept, empty on drain, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      oh_o        <= '0;
      bin_o       <= '0;
      err_o       <= 1'b0;
      mode_o      <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      mode_o      <= mode_i;
      oh_o        <= mode_i ? '0 : enc_oh;
      bin_o       <= mode_i ? dec_bin : '0;
      err_o       <= mode_i && dec_err;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

`ifdef ONE_HOT_ERR_CNT_EN
  // Saturating decode-error counter; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_o <= '0;
    end else if (err_clr_i) begin
      err_cnt_o <= '0;
    end else if (accept && mode_i && dec_err && (err_cnt_o != 16'hFFFF)) begin
      err_cnt_o <= err_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_one_hot_codec.sv
// Self-checking bench for one_hot_codec (BIN_W=4): vector table, sweeps and
// hand-written backpressure / mode-switch / reset sequences, scoreboard-checked.
module tb_one_hot_codec;

  typedef struct {
    logic        mode;
    logic [15:0] oh;
    logic [3:0]  bin;
    logic        err;
  } exp_t;

  typedef struct {
    logic        mode;
    logic [3:0]  bin;
    logic [15:0] oh;
    exp_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  bin_i;
  logic [15:0] oh_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] oh_o;
  logic [3:0]  bin_o;
  logic        err_o;
  logic        mode_o;
`ifdef ONE_HOT_ERR_CNT_EN
  logic        err_clr_i;
  logic [15:0] err_cnt_o;
`endif

  one_hot_codec #(.BIN_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode_i      (mode_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .bin_i       (bin_i),
    .oh_i        (oh_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .oh_o        (oh_o),
    .bin_o       (bin_o),
    .err_o       (err_o),
    .mode_o      (mode_o)
`ifdef ONE_HOT_ERR_CNT_EN
    ,
    .err_clr_i   (err_clr_i),
    .err_cnt_o   (err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_out    = 0;
  exp_t sb[$];
  exp_t pend;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Independent reference: encode shift, decode by counting set bits.
  function automatic exp_t model(input logic m, input logic [3:0] b, input logic [15:0] o);
    exp_t e;
    int   cnt;
    e.mode = m; e.oh = '0; e.bin = '0; e.err = 1'b0;
    if (!m) begin
      e.oh = 16'h0001 << b;
    end else begin
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
        if (o[i]) begin
          if (cnt == 0) e.bin = 4'(i);
          cnt++;
        end
      end
      e.err = (cnt != 1);
    end
    return e;
  endfunction

  // One clock: at the falling edge record an accept and check a transfer.
  task automatic step(output bit acc);
    exp_t e;
    @(negedge clk);
    acc = in_valid_i && in_ready_o;
    if (acc) sb.push_back(pend);
    if (out_valid_o && out_ready_i) begin
      n_out++;
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(oh_o), 32'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("mode_o", 32'(mode_o), 32'(e.mode));
        chk("oh_o",   32'(oh_o),   32'(e.oh));
        chk("bin_o",  32'(bin_o),  32'(e.bin));
        chk("err_o",  32'(err_o),  32'(e.err));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic m, input logic [3:0] b, input logic [15:0] o, input exp_t e);
    mode_i = m; bin_i = b; oh_i = o; in_valid_i = 1'b1; pend = e;
  endtask

  task automatic send(input logic m, input logic [3:0] b, input logic [15:0] o, input exp_t e);
    bit acc;
    int n;
    drive(m, b, o, e);
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      step(acc);
      if (!acc) out_ready_i = 1'b1;
      n++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid_i = 1'b0;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0;
    int   n0;
    bit   acc;
    exp_t e;
    logic m;
    logic [3:0]  rb;
    logic [15:0] ro;

    vt[0] = '{1'b1, 4'd0, 16'h0400, '{1'b1, 16'h0000, 4'hA, 1'b0}};
    vt[1] = '{1'b1, 4'd0, 16'h8000, '{1'b1, 16'h0000, 4'hF, 1'b0}};
    vt[2] = '{1'b1, 4'd0, 16'h0000, '{1'b1, 16'h0000, 4'h0, 1'b1}};
    vt[3] = '{1'b1, 4'd0, 16'h0120, '{1'b1, 16'h0000, 4'h5, 1'b1}};
    vt[4] = '{1'b1, 4'd0, 16'h0001, '{1'b1, 16'h0000, 4'h0, 1'b0}};
    vt[5] = '{1'b1, 4'd0, 16'hC000, '{1'b1, 16'h0000, 4'hE, 1'b1}};
    vt[6] = '{1'b0, 4'd15, 16'h0001, '{1'b0, 16'h8000, 4'h0, 1'b0}};
    vt[7] = '{1'b0, 4'd0, 16'hFFFF, '{1'b0, 16'h0001, 4'h0, 1'b0}};

    rst = 1'b1; mode_i = 1'b0; in_valid_i = 1'b0; bin_i = '0; oh_i = '0;
    out_ready_i = 1'b1;
`ifdef ONE_HOT_ERR_CNT_EN
    err_clr_i = 1'b0;
`endif
    #2;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_oh",        32'(oh_o),        32'd0);
    chk("rst_bin",       32'(bin_o),       32'd0);
    chk("rst_err",       32'(err_o),       32'd0);
    chk("rst_mode",      32'(mode_o),      32'd0);
    chk("rst_in_ready",  32'(in_ready_o),  32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Latency: result visible the cycle after accept.
    send(1'b0, 4'd3, 16'h0, model(1'b0, 4'd3, 16'h0));
    chk("lat_valid", 32'(out_valid_o), 32'd1);
    chk("lat_oh",    32'(oh_o),        32'h0008);
    idle(2);

    // Encode sweep at full rate.
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      e = '{1'b0, 16'h0001 << i, 4'h0, 1'b0};
      send(1'b0, 4'(i), 16'h0, e);
    end
    chk("sweep_cycles", 32'(cyc - c0), 32'd16);
    idle(2);

    // Vector table.
    foreach (vt[i]) send(vt[i].mode, vt[i].bin, vt[i].oh, vt[i].exp);
    idle(2);

`ifdef ONE_HOT_ERR_CNT_EN
    err_clr_i = 1'b1; idle(1); err_clr_i = 1'b0;
    chk("cnt_cleared", 32'(err_cnt_o), 32'd0);
    send(1'b1, 4'd0, 16'h0000, model(1'b1, 4'd0, 16'h0000));
    send(1'b1, 4'd0, 16'h0400, model(1'b1, 4'd0, 16'h0400));
    send(1'b1, 4'd0, 16'h0120, model(1'b1, 4'd0, 16'h0120));
    send(1'b0, 4'd0, 16'h0000, model(1'b0, 4'd0, 16'h0000));
    idle(2);
    chk("cnt_two", 32'(err_cnt_o), 32'd2);
    err_clr_i = 1'b1; idle(1); err_clr_i = 1'b0;
    chk("cnt_clr", 32'(err_cnt_o), 32'd0);
`endif

    // Backpressure: stall 4 cycles with a waiting word, then release.
    out_ready_i = 1'b0;
    send(1'b0, 4'd3, 16'h0, model(1'b0, 4'd3, 16'h0));
    n0 = n_out;
    drive(1'b0, 4'd7, 16'h0, model(1'b0, 4'd7, 16'h0));
    for (int i = 0; i < 4; i++) begin
      step(acc);
      chk("bp_in_ready",  32'(in_ready_o),  32'd0);
      chk("bp_oh_hold",   32'(oh_o),        32'h0008);
      chk("bp_valid",     32'(out_valid_o), 32'd1);
    end
    out_ready_i = 1'b1;
    step(acc);
    chk("bp_accept_on_release", 32'(acc), 32'd1);
    in_valid_i = 1'b0;
    chk("bp_next_oh", 32'(oh_o), 32'h0080);
    idle(3);
    chk("bp_out_count", 32'(n_out - n0), 32'd2);
    chk("bp_sb_empty",  32'(sb.size()),  32'd0);

    // Mode interleave at full rate.
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) send(1'b0, 4'd2, 16'h0, '{1'b0, 16'h0004, 4'h0, 1'b0});
      else            send(1'b1, 4'd0, 16'h0004, '{1'b1, 16'h0000, 4'h2, 1'b0});
    end
    chk("mix_cycles", 32'(cyc - c0), 32'd8);
    idle(2);

    // Random traffic with random backpressure.
    for (int i = 0; i < 40; i++) begin
      m  = 1'($urandom_range(0, 1));
      rb = 4'($urandom_range(0, 15));
      ro = (i % 3 == 0) ? 16'($urandom) : (16'h0001 << $urandom_range(0, 15));
      out_ready_i = 1'($urandom_range(0, 1));
      send(m, rb, ro, model(m, rb, ro));
    end
    out_ready_i = 1'b1;
    idle(3);
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-stream while stalled on a decode word.
    out_ready_i = 1'b0;
    send(1'b1, 4'd0, 16'h0400, model(1'b1, 4'd0, 16'h0400));
    idle(1);
    chk("pre_rst_valid", 32'(out_valid_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid",    32'(out_valid_o), 32'd0);
    chk("arst_bin",      32'(bin_o),       32'd0);
    chk("arst_mode",     32'(mode_o),      32'd0);
    chk("arst_oh",       32'(oh_o),        32'd0);
    chk("arst_in_ready", 32'(in_ready_o),  32'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    send(1'b0, 4'd9, 16'h0, model(1'b0, 4'd9, 16'h0));
    chk("post_rst_valid", 32'(out_valid_o), 32'd1);
    chk("post_rst_oh",    32'(oh_o),        32'h0200);
    idle(3);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
